// File: rtl/aes1_job_master_if.sv
// Register-bus bundle between the AES job master and the AES register block.
// One outstanding access; request fields hold until grant, reads return later.
interface aes1_job_master_if;
    logic        bus_req_o;
    logic        bus_gnt_i;
    logic        bus_we_o;
    logic [63:0] bus_addr_o;
    logic [63:0] bus_wdata_o;
    logic        bus_rvalid_i;
    logic [63:0] bus_rdata_i;

    modport master (
        output bus_req_o,
        output bus_we_o,
        output bus_addr_o,
        output bus_wdata_o,
        input  bus_gnt_i,
        input  bus_rvalid_i,
        input  bus_rdata_i
    );

    modport slave (
        input  bus_req_o,
        input  bus_we_o,
        input  bus_addr_o,
        input  bus_wdata_o,
        output bus_gnt_i,
        output bus_rvalid_i,
        output bus_rdata_i
    );
endinterface

// File: rtl/aes1_job_master.sv
// Drives one AES job (key, mode, block) through the AES register block and returns the result.
// Optional AES1_JOB_MASTER_KEYCACHE_EN skips key load/expansion when the key is unchanged.
module aes1_job_master #(
    parameter logic [63:0] BASE_ADDR     = 64'h0,
    parameter int unsigned POLL_LIMIT    = 4096,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              job_valid_i,
    output logic              job_ready_o,
    input  logic [255:0]      job_key_i,
    input  logic              job_keylen_i,
    input  logic [1:0]        job_keysel_i,
    input  logic              job_encdec_i,
    input  logic [127:0]      job_block_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [127:0]      res_data_o,
    output logic              res_err_o,
    aes1_job_master_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_KEYSEL, S_WR_KEYLEN, S_WR_KEY,
        S_WR_ENCDEC, S_WR_BLOCK, S_INIT_SET, S_INIT_CLR,
        S_SETTLE_R, S_POLL_RDY, S_NEXT_SET, S_NEXT_CLR,
        S_SETTLE_V, S_POLL_VLD, S_RD_RES, S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic [31:0]    settle_q, settle_d;
    logic [31:0]    poll_q, poll_d;
    logic           wait_q, wait_d;
    logic [255:0]   key_q, key_d;
    logic           keylen_q, keylen_d;
    logic [1:0]     keysel_q, keysel_d;
    logic           encdec_q, encdec_d;
    logic [127:0]   block_q, block_d;
    logic [127:0]   res_q, res_d;
    logic           err_q, err_d;
`ifdef AES1_JOB_MASTER_KEYCACHE_EN
    logic           hit_q, hit_d;
    logic           cvld_q, cvld_d;
    logic [255:0]   ckey_q, ckey_d;
    logic           clen_q, clen_d;
    logic [1:0]     csel_q, csel_d;
`endif

    logic        req;
    logic        we;
    logic [11:0] off;
    logic [31:0] wd;
    logic        gnt;
    logic        rd_done;
    logic        unused_rdata;

    assign unused_rdata = ^bus.bus_rdata_i[63:32];

    // Request fields decode purely from registered state, so they hold until grant.
    always_comb begin
        req = 1'b0;
        we  = 1'b0;
        off = 12'h000;
        wd  = 32'h0;
        unique case (state_q)
            S_WR_KEYSEL: begin
                req = 1'b1; we = 1'b1; off = 12'h070;
                wd  = {30'd0, keysel_q};
            end
            S_WR_KEYLEN: begin
                req = 1'b1; we = 1'b1;
                off = 12'h058 + {7'd0, keysel_q, 3'd0};
                wd  = {31'd0, keylen_q};
            end
            S_WR_KEY: begin
                req = 1'b1; we = 1'b1;
                off = 12'h080 + {3'd0, keysel_q, 7'd0} + {6'd0, idx_q, 3'd0};
                wd  = key_q[{idx_q, 5'd0} +: 32];
            end
            S_WR_ENCDEC: begin
                req = 1'b1; we = 1'b1; off = 12'h050;
                wd  = {31'd0, encdec_q};
            end
            S_WR_BLOCK: begin
                req = 1'b1; we = 1'b1;
                off = 12'h200 + {7'd0, idx_q[1:0], 3'd0};
                wd  = block_q[{idx_q[1:0], 5'd0} +: 32];
            end
            S_INIT_SET: begin req = 1'b1; we = 1'b1; off = 12'h040; wd = 32'd1; end
            S_INIT_CLR: begin req = 1'b1; we = 1'b1; off = 12'h040; end
            S_NEXT_SET: begin req = 1'b1; we = 1'b1; off = 12'h040; wd = 32'd2; end
            S_NEXT_CLR: begin req = 1'b1; we = 1'b1; off = 12'h040; end
            S_POLL_RDY, S_POLL_VLD: begin req = !wait_q; off = 12'h048; end
            S_RD_RES: begin
                req = !wait_q;
                off = 12'h280 + {7'd0, idx_q[1:0], 3'd0};
            end
            default: ;
        endcase
    end

    assign bus.bus_req_o   = req;
    assign bus.bus_we_o    = req & we;
    assign bus.bus_addr_o  = req ? BASE_ADDR + {52'd0, off} : 64'h0;
    assign bus.bus_wdata_o = (req & we) ? {32'd0, wd} : 64'h0;

    assign gnt     = req & bus.bus_gnt_i;
    assign rd_done = wait_q & bus.bus_rvalid_i;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        poll_d   = poll_q;
        wait_d   = wait_q;
        key_d    = key_q;
        keylen_d = keylen_q;
        keysel_d = keysel_q;
        encdec_d = encdec_q;
        block_d  = block_q;
        res_d    = res_q;
        err_d    = err_q;
`ifdef AES1_JOB_MASTER_KEYCACHE_EN
        hit_d    = hit_q;
        cvld_d   = cvld_q;
        ckey_d   = ckey_q;
        clen_d   = clen_q;
        csel_d   = csel_q;
`endif
        unique case (state_q)
            S_IDLE: if (job_valid_i) begin
                key_d    = job_key_i;
                keylen_d = job_keylen_i;
                keysel_d = job_keysel_i;
                encdec_d = job_encdec_i;
                block_d  = job_block_i;
                res_d    = '0;
                err_d    = 1'b0;
                idx_d    = '0;
                poll_d   = '0;
                wait_d   = 1'b0;
                state_d  = S_WR_KEYSEL;
`ifdef AES1_JOB_MASTER_KEYCACHE_EN
                hit_d = cvld_q && job_key_i == ckey_q &&
                        job_keylen_i == clen_q && job_keysel_i == csel_q;
                if (hit_d) state_d = S_WR_ENCDEC;
                else cvld_d = 1'b0;
`endif
            end
            S_WR_KEYSEL: if (gnt) state_d = S_WR_KEYLEN;
            S_WR_KEYLEN: if (gnt) begin state_d = S_WR_KEY; idx_d = '0; end
            S_WR_KEY: if (gnt) begin
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) state_d = S_WR_ENCDEC;
            end
            S_WR_ENCDEC: if (gnt) begin state_d = S_WR_BLOCK; idx_d = '0; end
            S_WR_BLOCK: if (gnt) begin
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd3) begin
                    idx_d   = '0;
                    state_d = S_INIT_SET;
`ifdef AES1_JOB_MASTER_KEYCACHE_EN
                    if (hit_q) state_d = S_NEXT_SET;
`endif
                end
            end
            S_INIT_SET: if (gnt) state_d = S_INIT_CLR;
            S_INIT_CLR: if (gnt) begin
                settle_d = '0;
                poll_d   = '0;
                state_d  = (SETTLE_CYCLES == 0) ? S_POLL_RDY : S_SETTLE_R;
            end
            S_SETTLE_R: begin
                settle_d = settle_q + 32'd1;
                if (settle_q == SETTLE_CYCLES - 1) state_d = S_POLL_RDY;
            end
            S_NEXT_SET: if (gnt) state_d = S_NEXT_CLR;
            S_NEXT_CLR: if (gnt) begin
                settle_d = '0;
                poll_d   = '0;
                state_d  = (SETTLE_CYCLES == 0) ? S_POLL_VLD : S_SETTLE_V;
            end
            S_SETTLE_V: begin
                settle_d = settle_q + 32'd1;
                if (settle_q == SETTLE_CYCLES - 1) state_d = S_POLL_VLD;
            end
            S_POLL_RDY, S_POLL_VLD: begin
                if (gnt) wait_d = 1'b1;
                if (rd_done) begin
                    wait_d = 1'b0;
                    if (state_q == S_POLL_RDY && bus.bus_rdata_i[0]) begin
                        state_d = S_NEXT_SET;
`ifdef AES1_JOB_MASTER_KEYCACHE_EN
                        cvld_d = 1'b1;
                        ckey_d = key_q;
                        clen_d = keylen_q;
                        csel_d = keysel_q;
`endif
                    end else if (state_q == S_POLL_VLD && bus.bus_rdata_i[1]) begin
                        state_d = S_RD_RES;
                        idx_d   = '0;
                    end else if (poll_q + 32'd1 == POLL_LIMIT) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        res_d   = '0;
`ifdef AES1_JOB_MASTER_KEYCACHE_EN
                        cvld_d = 1'b0;
`endif
                    end else begin
                        poll_d = poll_q + 32'd1;
                    end
                end
            end
            S_RD_RES: begin
                if (gnt) wait_d = 1'b1;
                if (rd_done) begin
                    wait_d = 1'b0;
                    res_d[{idx_q[1:0], 5'd0} +: 32] = bus.bus_rdata_i[31:0];
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd3) state_d = S_DONE;
                end
            end
            S_DONE: if (res_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            poll_q   <= '0;
            wait_q   <= 1'b0;
            key_q    <= '0;
            keylen_q <= 1'b0;
            keysel_q <= '0;
            encdec_q <= 1'b0;
            block_q  <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
`ifdef AES1_JOB_MASTER_KEYCACHE_EN
            hit_q    <= 1'b0;
            cvld_q   <= 1'b0;
            ckey_q   <= '0;
            clen_q   <= 1'b0;
            csel_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            poll_q   <= poll_d;
            wait_q   <= wait_d;
            key_q    <= key_d;
            keylen_q <= keylen_d;
            keysel_q <= keysel_d;
            encdec_q <= encdec_d;
            block_q  <= block_d;
            res_q    <= res_d;
            err_q    <= err_d;
`ifdef AES1_JOB_MASTER_KEYCACHE_EN
            hit_q    <= hit_d;
            cvld_q   <= cvld_d;
            ckey_q   <= ckey_d;
            clen_q   <= clen_d;
            csel_q   <= csel_d;
`endif
        end
    end

    assign job_ready_o = (state_q == S_IDLE);
    assign res_valid_o = (state_q == S_DONE);
    assign res_data_o  = res_q;
    assign res_err_o   = err_q;

endmodule
